// File: rtl/mem_arbiter.sv
// Byte-serial memory controller: arbitrates fetch and load/store ports onto the
// 8-bit memory bus, splits accesses into byte cycles and extends load results.
module mem_arbiter #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t          state_q, state_d;
  logic            port_q;        // 1 = data port, 0 = fetch port
  logic [AW-1:0]   base_q;
  logic [CW-1:0]   len_q, idx_q, rcv_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rbuf_q;
  logic            rd_vld_q;      // mem_a carries a read address this cycle
  logic            rd_pend_q;     // mem_din carries the byte for last cycle's address
  logic            frz_q;         // previous cycle was frozen by rdy
  logic            mem_wr_q;

  logic            go_ls_c, go_if_c, finish_c, wr_hold_c;
  logic [CW-1:0]   grant_len_c;
  logic [31:0]     merged_c, ext_c, io_addr_c;
  logic [7:0]      wbyte_c;

  // Arbitration and next-state; a port is masked while its done pulse is high
  always_comb begin
    state_d  = state_q;
    go_ls_c  = 1'b0;
    go_if_c  = 1'b0;
    finish_c = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (!clear) begin
            if (ls_req && !ls_done) begin
              go_ls_c = 1'b1;
              state_d = ls_we ? WRITE : READ;
            end else if (if_req && !if_done) begin
              go_if_c = 1'b1;
              state_d = READ;
            end
          end
        end
        READ: begin
          if (clear) begin
            state_d = IDLE;
          end else if (!frz_q && rd_pend_q && (CW'(rcv_q + CW'(1)) == len_q)) begin
            finish_c = 1'b1;
            state_d  = IDLE;
          end
        end
        WRITE: begin
          if (idx_q == len_q) begin
            finish_c = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    grant_len_c = CW'(4);
    if (go_ls_c) begin
      case (ls_size)
        2'b00:   grant_len_c = CW'(1);
        2'b01:   grant_len_c = CW'(2);
        default: grant_len_c = CW'(4);
      endcase
    end
    io_addr_c = (state_q == IDLE) ? ls_addr : base_q;
    wr_hold_c = (io_addr_c[17:16] == IO_SEL) && io_buffer_full;
    case (idx_q[1:0])
      2'd0:    wbyte_c = wdata_q[7:0];
      2'd1:    wbyte_c = wdata_q[15:8];
      2'd2:    wbyte_c = wdata_q[23:16];
      default: wbyte_c = wdata_q[31:24];
    endcase
  end

  // Gathered word including the byte arriving this cycle, then load extension
  always_comb begin
    merged_c = rbuf_q;
    case (rcv_q[1:0])
      2'd0:    merged_c[7:0]   = mem_din;
      2'd1:    merged_c[15:8]  = mem_din;
      2'd2:    merged_c[23:16] = mem_din;
      default: merged_c[31:24] = mem_din;
    endcase
    case (size_q)
      2'b00:   ext_c = {{24{signed_q & merged_c[7]}}, merged_c[7:0]};
      2'b01:   ext_c = {{16{signed_q & merged_c[15]}}, merged_c[15:0]};
      default: ext_c = merged_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q    <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rcv_q     <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      frz_q     <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= '0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      if_data   <= '0;
      ls_rdata  <= '0;
    end else if (!rdy) begin
      frz_q <= 1'b1;
    end else begin
      frz_q    <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_ls_c || go_if_c) begin
            port_q    <= go_ls_c;
            base_q    <= go_ls_c ? ls_addr : if_addr;
            len_q     <= grant_len_c;
            size_q    <= go_ls_c ? ls_size : 2'b10;
            signed_q  <= go_ls_c && ls_signed;
            wdata_q   <= ls_wdata;
            rbuf_q    <= '0;
            rcv_q     <= '0;
            rd_pend_q <= 1'b0;
            mem_a     <= go_ls_c ? ls_addr : if_addr;
            if (go_ls_c && ls_we) begin
              rd_vld_q <= 1'b0;
              if (wr_hold_c) begin
                idx_q <= '0;
              end else begin
                idx_q    <= CW'(1);
                mem_dout <= ls_wdata[7:0];
                mem_wr_q <= 1'b1;
              end
            end else begin
              idx_q    <= CW'(1);
              rd_vld_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (clear) begin
            rd_vld_q  <= 1'b0;
            rd_pend_q <= 1'b0;
          end else if (frz_q) begin
            // A freeze breaks the address/data pairing: restart from the first missing byte
            mem_a     <= base_q + AW'(rcv_q);
            idx_q     <= CW'(rcv_q + CW'(1));
            rd_vld_q  <= 1'b1;
            rd_pend_q <= 1'b0;
          end else if (finish_c) begin
            rd_vld_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rcv_q     <= CW'(rcv_q + CW'(1));
            if (port_q) begin
              ls_done  <= 1'b1;
              ls_rdata <= ext_c;
            end else begin
              if_done <= 1'b1;
              if_data <= merged_c;
            end
          end else begin
            if (rd_pend_q) begin
              rbuf_q <= merged_c;
              rcv_q  <= CW'(rcv_q + CW'(1));
            end
            rd_pend_q <= rd_vld_q;
            if (idx_q < len_q) begin
              mem_a    <= base_q + AW'(idx_q);
              idx_q    <= CW'(idx_q + CW'(1));
              rd_vld_q <= 1'b1;
            end else begin
              rd_vld_q <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (finish_c) begin
            ls_done <= 1'b1;
          end else if (!wr_hold_c) begin
            mem_a    <= base_q + AW'(idx_q);
            mem_dout <= wbyte_c;
            mem_wr_q <= 1'b1;
            idx_q    <= CW'(idx_q + CW'(1));
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_wr = mem_wr_q & rdy;

endmodule
